// File: rtl/aud_pkg.sv
// rtl/aud_pkg.sv - shared audio constants and player state encoding
package aud_pkg;

    localparam int ADDR_W = 20;
    localparam int DATA_W = 16;
    localparam logic [ADDR_W-1:0] MAX_ADDR = 20'd1024000;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_SHIFT  = 3'd2,
        S_HOLD   = 3'd3,
        S_PAUSE  = 3'd4,
        S_FINISH = 3'd5
    } aud_state_e;

endpackage

// File: rtl/aud_player_if.sv
// rtl/aud_player_if.sv - SRAM read port and codec DAC lines of the playback engine
interface aud_player_if import aud_pkg::*; #(
    parameter int ADDR_W = aud_pkg::ADDR_W,
    parameter int DATA_W = aud_pkg::DATA_W
);
    logic [ADDR_W-1:0] o_address;
    logic [DATA_W-1:0] i_sram_data;
    logic              i_lrc;
    logic              o_dac_data;

    modport master (output o_address, output o_dac_data, input i_sram_data, input i_lrc);
    modport slave  (input o_address, input o_dac_data, output i_sram_data, output i_lrc);
endinterface

// File: rtl/aud_ser.sv
// rtl/aud_ser.sv - MSB-first PISO for one sample with a bit counter
module aud_ser import aud_pkg::*; #(
    parameter int DATA_W = aud_pkg::DATA_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  logic              i_shift,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_bit,
    output logic              o_done
);
    localparam int CNT_W = $clog2(DATA_W) + 1;

    logic [DATA_W-1:0] sr_q, sr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (i_load) begin
            sr_d  = i_data;
            cnt_d = CNT_W'(1);
        end else if (i_shift) begin
            sr_d  = sr_q << 1;
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // o_bit is the value to register onto DACDAT this edge: the MSB on load, then each following bit
    assign o_bit  = i_load ? i_data[DATA_W-1] : sr_q[DATA_W-2];
    assign o_done = (cnt_q == CNT_W'(DATA_W));

    always_ff @(negedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/aud_player.sv
// rtl/aud_player.sv - I2S playback engine: SRAM walk, left-slot serialisation, pause/stop/slow-motion
module aud_player import aud_pkg::*; #(
    parameter int ADDR_W = aud_pkg::ADDR_W,
    parameter int DATA_W = aud_pkg::DATA_W,
    parameter int REP_W  = 3
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_pause,
    input  logic              i_stop,
    input  logic [ADDR_W-1:0] i_end_addr,
    input  logic [REP_W-1:0]  i_slow,
    aud_player_if.master      bus,
    output logic              o_playing,
    output logic              o_finish
);
    aud_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, end_q, end_d;
    logic [REP_W-1:0]  rep_q, rep_d, slow_q, slow_d;
    logic              dac_q, dac_d, lrc_q, pend_q, pend_d;
    logic              fe, active, ser_load, ser_shift, ser_bit, ser_done;

    assign fe     = lrc_q & ~bus.i_lrc;
    assign active = (state_q == S_WAIT) || (state_q == S_SHIFT) ||
                    (state_q == S_HOLD) || (state_q == S_PAUSE);

    aud_ser #(.DATA_W(DATA_W)) u_ser (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (ser_load),
        .i_shift (ser_shift),
        .i_data  (bus.i_sram_data),
        .o_bit   (ser_bit),
        .o_done  (ser_done)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        end_d     = end_q;
        rep_d     = rep_q;
        slow_d    = slow_q;
        dac_d     = dac_q;
        pend_d    = pend_q;
        ser_load  = 1'b0;
        ser_shift = 1'b0;
        if (active && i_stop) begin
            state_d = S_FINISH;
            dac_d   = 1'b0;
            pend_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    dac_d = 1'b0;
                    if (i_start) begin
                        state_d = S_WAIT;
                        addr_d  = '0;
                        rep_d   = '0;
                        end_d   = i_end_addr;
                        slow_d  = i_slow;
                        pend_d  = 1'b0;
                    end
                end
                S_WAIT: begin
                    dac_d = 1'b0;
                    if (i_pause) pend_d = 1'b1;
                    if (fe) begin
                        ser_load = 1'b1;
                        dac_d    = ser_bit;
                        state_d  = S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (i_pause) pend_d = 1'b1;
                    if (ser_done) begin
                        dac_d   = 1'b0;
                        state_d = S_HOLD;
                    end else begin
                        ser_shift = 1'b1;
                        dac_d     = ser_bit;
                    end
                end
                S_HOLD: begin
                    // Frame boundary: advance repeat/address, then honour a pending pause
                    dac_d = 1'b0;
                    if (rep_q != slow_q) begin
                        rep_d = rep_q + REP_W'(1);
                    end else if (addr_q != end_q) begin
                        addr_d = addr_q + ADDR_W'(1);
                        rep_d  = '0;
                    end
                    if ((rep_q == slow_q) && (addr_q == end_q)) begin
                        state_d = S_FINISH;
                    end else if (pend_q || i_pause) begin
                        state_d = S_PAUSE;
                        pend_d  = 1'b0;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
                S_PAUSE: begin
                    dac_d = 1'b0;
                    if (i_pause) state_d = S_WAIT;
                end
                S_FINISH: begin
                    dac_d   = 1'b0;
                    addr_d  = '0;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(negedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            end_q   <= '0;
            rep_q   <= '0;
            slow_q  <= '0;
            dac_q   <= 1'b0;
            lrc_q   <= 1'b1;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            end_q   <= end_d;
            rep_q   <= rep_d;
            slow_q  <= slow_d;
            dac_q   <= dac_d;
            lrc_q   <= bus.i_lrc;
            pend_q  <= pend_d;
        end
    end

    assign bus.o_address  = addr_q;
    assign bus.o_dac_data = dac_q;
    assign o_playing      = (state_q == S_WAIT) || (state_q == S_SHIFT) || (state_q == S_HOLD);
    assign o_finish       = (state_q == S_FINISH);
endmodule

// File: tb/tb_aud_player.sv
// tb/tb_aud_player.sv - scoreboard bench for aud_player with a frame-level reference model
module tb_aud_player;
    import aud_pkg::*;

    typedef struct {
        logic [15:0] word;
        logic [19:0] addr;
    } exp_t;

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, pause = 1'b0, stop = 1'b0;
    logic [19:0] end_addr = '0;
    logic [2:0]  slow = '0;
    logic        playing, finish;
    logic [15:0] mem [32];
    int          phase = 63;
    int          checks = 0, errors = 0;
    int          frames_seen = 0, fin_cnt = 0;
    logic        mon_en = 1'b0, cap_on = 1'b0, zero_bad = 1'b0;
    logic [15:0] word;
    exp_t        cur;
    exp_t        exp_q[$];

    aud_player_if bus();
    assign bus.i_sram_data = mem[bus.o_address[4:0]];

    aud_player dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (start),
        .i_pause    (pause),
        .i_stop     (stop),
        .i_end_addr (end_addr),
        .i_slow     (slow),
        .bus        (bus),
        .o_playing  (playing),
        .o_finish   (finish)
    );

    always #5 clk = ~clk;

    // 64 BCLK per LRC period, left slot (LRC low) first
    initial begin
        bus.i_lrc = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            phase     = (phase + 1) % 64;
            bus.i_lrc = (phase >= 32);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: phase p sampled at a posedge is the value DACDAT took at the falling edge of phase p
    initial forever begin
        @(posedge clk);
        if (finish) fin_cnt++;
        if (!mon_en || !rst_n) begin
            cap_on   = 1'b0;
            zero_bad = 1'b0;
        end else begin
            if (phase == 0 && playing) begin
                frames_seen++;
                check("frame_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    cur = exp_q.pop_front();
                    check("frame_addr", bus.o_address, cur.addr);
                    cap_on = 1'b1;
                end
            end
            if (cap_on && phase < 16) begin
                word[15-phase] = bus.o_dac_data;
                if (phase == 15) begin
                    check("frame_word", word, cur.word);
                    cap_on = 1'b0;
                end
            end else if (bus.o_dac_data !== 1'b0) begin
                zero_bad = 1'b1;
            end
            if (phase == 63) begin
                check("dac_zero_outside_sample", zero_bad, 0);
                zero_bad = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_phase(input int p);
        for (int i = 0; i < 80 && phase != p; i++) step();
    endtask

    task automatic pulse(input logic s, input logic p, input logic t);
        start = s; pause = p; stop = t;
        step();
        start = 1'b0; pause = 1'b0; stop = 1'b0;
    endtask

    task automatic load_model(input int e, input int s);
        exp_q.delete();
        for (int a = 0; a <= e; a++)
            for (int r = 0; r <= s; r++)
                exp_q.push_back('{mem[a], 20'(a)});
    endtask

    task automatic wait_frames(input int n, input int lim);
        for (int i = 0; i < lim && frames_seen < n; i++) step();
        check("frame_progress", frames_seen >= n, 1);
    endtask

    task automatic begin_play(input int e, input int s, input logic with_stop);
        int fs0;
        end_addr = 20'(e);
        slow     = 3'(s);
        load_model(e, s);
        mon_en   = 1'b1;
        wait_phase($urandom_range(20, 50));
        fs0 = frames_seen;
        pulse(1'b1, 1'b0, with_stop);
        wait_frames(fs0 + 1, 70);
    endtask

    task automatic end_play(input int lim, input int f0);
        for (int i = 0; i < lim && fin_cnt == f0; i++) step();
        check("finish_seen", fin_cnt != f0, 1);
        repeat (70) step();
        check("finish_single", fin_cnt, f0 + 1);
        check("frames_remaining", exp_q.size(), 0);
        check("addr_after_finish", bus.o_address, 0);
        check("playing_after_finish", playing, 0);
    endtask

    task automatic play(input int e, input int s, input logic with_stop);
        int f0;
        f0 = fin_cnt;
        begin_play(e, s, with_stop);
        end_play((e + 1) * (s + 1) * 64 + 128, f0);
    endtask

    task automatic pause_test();
        int f0;
        logic held_ok, no_frames;
        int fs;
        for (int a = 0; a < 4; a++) mem[a] = 16'($urandom);
        f0 = fin_cnt;
        begin_play(3, 0, 1'b0);
        wait_frames(frames_seen + 1, 100);
        wait_phase(5);
        pulse(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 80 && playing; i++) step();
        check("pause_entered", playing, 0);
        check("pause_addr", bus.o_address, 2);
        held_ok = 1'b1;
        fs = frames_seen;
        repeat (150) begin
            step();
            if (playing || bus.o_address != 20'd2) held_ok = 1'b0;
        end
        no_frames = (frames_seen == fs);
        check("pause_held", held_ok, 1);
        check("pause_no_frames", no_frames, 1);
        pulse(1'b0, 1'b1, 1'b0);
        end_play(4 * 64, f0);
    endtask

    task automatic abort_test(input logic s, input logic p, input string name);
        int f0;
        for (int a = 0; a < 6; a++) mem[a] = 16'($urandom);
        mem[1] = 16'hFFFF;
        begin_play(5, 0, 1'b0);
        wait_frames(frames_seen + 1, 100);
        wait_phase(7);
        mon_en = 1'b0;
        f0 = fin_cnt;
        start = s; pause = p; stop = 1'b1;
        @(posedge clk);
        #1;
        check({name, "_dac"}, bus.o_dac_data, 0);
        check({name, "_finish"}, finish, 1);
        check({name, "_playing"}, playing, 0);
        start = 1'b0; pause = 1'b0; stop = 1'b0;
        @(posedge clk);
        #1;
        check({name, "_finish_drop"}, finish, 0);
        check({name, "_addr"}, bus.o_address, 0);
        exp_q.delete();
        step();
        repeat (100) step();
        check({name, "_idle"}, playing, 0);
        check({name, "_fin_count"}, fin_cnt, f0 + 1);
    endtask

    task automatic reset_test();
        logic stayed_idle;
        for (int a = 0; a < 4; a++) mem[a] = 16'hFFFF;
        begin_play(3, 0, 1'b0);
        wait_frames(frames_seen + 1, 100);
        wait_phase(3);
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("rst_async_dac", bus.o_dac_data, 0);
        check("rst_async_addr", bus.o_address, 0);
        check("rst_async_playing", playing, 0);
        check("rst_async_finish", finish, 0);
        step();
        rst_n = 1'b1;
        exp_q.delete();
        stayed_idle = 1'b1;
        repeat (140) begin
            step();
            if (playing) stayed_idle = 1'b0;
        end
        check("rst_stays_idle", stayed_idle, 1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int a = 0; a < 32; a++) mem[a] = '0;
        repeat (3) step();
        check("reset_addr", bus.o_address, 0);
        check("reset_dac", bus.o_dac_data, 0);
        check("reset_playing", playing, 0);
        check("reset_finish", finish, 0);
        rst_n = 1'b1;
        step();

        mem[0] = 16'hA5A5; mem[1] = 16'h8001; mem[2] = 16'h7FFE;
        play(2, 0, 1'b0);

        mem[0] = 16'($urandom); mem[1] = 16'($urandom);
        play(1, 2, 1'b0);

        mem[0] = 16'($urandom);
        play(0, 0, 1'b1);

        for (int run = 0; run < 4; run++) begin
            int e, s;
            e = $urandom_range(0, 4);
            s = $urandom_range(0, 3);
            for (int a = 0; a <= e; a++) mem[a] = 16'($urandom);
            play(e, s, 1'b0);
        end

        pause_test();
        abort_test(1'b0, 1'b0, "stop");
        abort_test(1'b1, 1'b0, "start_stop");
        abort_test(1'b0, 1'b1, "pause_stop");
        reset_test();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/aud_player.md
Name: aud_player

Overview:
- I2S playback engine: the DAC-side counterpart of the recorder.
- Walks SRAM addresses, fetches one 16-bit sample per LRC frame and shifts it MSB-first onto the codec DACDAT line in the left-channel slot.
- Supports start/pause/stop, slow-motion sample repeat and end-of-recording detection.
- Sits between the top-level FSM and SRAM/WM8731; both SRAM and codec are shared with the recorder, arbitration is done in top.

Parameters:
- ADDR_W, 20, SRAM word-address width
- DATA_W, 16, sample width; bits per channel slot
- REP_W, 3, width of the repeat-factor input

Ports:
- i_clk  input  1  codec bit clock (BCLK); all flops update on the falling edge
- i_rst_n  input  1  asynchronous active-low reset
- i_lrc  input  1  codec DACLRCK; low = left channel
- i_start  input  1  one-cycle pulse, start playback from address 0
- i_pause  input  1  one-cycle pulse, toggles pause/resume
- i_stop  input  1  one-cycle pulse, abort playback
- i_end_addr  input  ADDR_W  last valid sample address; captured on accepted start
- i_slow  input  REP_W  each sample is played i_slow+1 times; captured on accepted start
- i_sram_data  input  DATA_W  SRAM read data for o_address
- o_address  output  ADDR_W  SRAM read address
- o_dac_data  output  1  serial DAC data
- o_playing  output  1  high in WAIT/SHIFT/HOLD
- o_finish  output  1  one-cycle completion pulse

Behaviour:
- Reset (async, i_rst_n=0): state IDLE; o_address=0, o_dac_data=0, o_playing=0, o_finish=0, shift register=0, bit counter=0, repeat counter=0, lrc_d=1.
- lrc_d is a registered copy of i_lrc.
- Left-frame edge (fe) = lrc_d==1 && i_lrc==0, evaluated at a falling edge.
- States:
  - IDLE: i_start -> WAIT, o_address=0, repeat=0, end/slow captured.
  - WAIT: o_dac_data=0. On fe: load shift reg from i_sram_data, o_dac_data<=i_sram_data[15], bit=1 -> SHIFT.
  - SHIFT: each edge o_dac_data<=next bit (14..0), bit++. After bit 0 has been driven for one edge -> HOLD with o_dac_data<=0.
    - Net result: the MSB appears on the first falling edge after LRC falls, which is the I2S one-BCLK delay.
  - HOLD: o_dac_data=0 for the rest of the left slot and all of the right slot. Frame-advance occurs on HOLD entry (one edge):
    - If repeat==slow_q, then: if o_address==end_q -> FINISH; else o_address+1, repeat=0.
    - Otherwise repeat+1.
    - If a pause request is pending -> PAUSE, else -> WAIT.
  - PAUSE: o_dac_data=0, o_address held, o_playing=0. i_pause -> WAIT (resumes at the next fe, same address/repeat).
  - FINISH: o_finish=1 for exactly one cycle, o_address<=0 -> IDLE.
- Pause is latched as pending and takes effect only at a frame boundary (HOLD entry), so a sample is never truncated.
- i_stop in WAIT/SHIFT/HOLD/PAUSE -> FINISH on the next edge. o_dac_data<=0 immediately and a partial sample is dropped.
- Priority on simultaneous pulses: stop > pause > start. i_start outside IDLE is ignored; i_pause in IDLE is ignored.
- Address never exceeds end_q.
- end_addr=0 plays exactly one sample (times slow+1).
- fe arriving while still in SHIFT (i.e. fewer than 17 BCLK per half-frame) is a protocol violation: the block finishes the current sample and does not resync.
- Latency: start pulse -> first MSB on DACDAT = next fe, i.e. at most one LRC period.

Decomposition:
- Package aud_pkg:
  - state enum: S_IDLE, S_WAIT, S_SHIFT, S_HOLD, S_PAUSE, S_FINISH
  - constants: ADDR_W, DATA_W, MAX_ADDR = 20'd1024000
  - shared with the recorder
- Sub-module aud_ser: PISO 16-bit shift register with load/shift enables and bit counter, output done flag.
- aud_player keeps the FSM, address and repeat logic.

Test Plan:
- Reset mid-SHIFT (i_rst_n low for 1 BCLK) -> all outputs 0 asynchronously, IDLE, o_address=0.
- start, end_addr=2, slow=0, SRAM words 0xA5A5/0x8001/0x7FFE, BCLK=64·LRC -> DACDAT left slots carry exactly those MSB-first starting 1 BCLK after each LRC fall; right slots 0; o_address 0,1,2; o_finish pulse after the third frame; o_address returns 0.
- slow=2, end_addr=1 -> each word serialized in 3 consecutive frames (6 frames total), then o_finish.
- pause pulse at bit 5 of frame 1 -> frame 1 completes in full, 0s output while paused with address held; second pause pulse -> resumes at frame 2 with the correct word.
- stop at bit 8 -> DACDAT 0 from next edge, o_finish high one cycle, o_playing 0.
- start+stop in the same cycle while IDLE -> start is taken (stop ignored in IDLE); start+stop while playing -> finish; pause+stop while playing -> finish, not pause.
